// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - multi-client arbiter for the shared 8-bit video/main SRAM
//
// Serialises accesses from CH clients onto the SRAM strobes. Channel 0 always
// wins; channels 1..CH-1 are served round-robin (RR=1) or lowest-index-first (RR=0).
//
// Ports:
//   clk28            sole clock
//   rst              asynchronous active-high reset
//   req/we           per-channel request (level, held until gnt) and write enable
//   addr/wdata       per-channel address (AW bits each) and write data (8 bits each)
//   gnt/done         one-cycle one-hot pulses: request latched / access complete
//   rdata            shared read data, valid while done is high for a read
//   busy             high while an access is in ACCESS or DONE
//   va               SRAM address
//   vd_in            SRAM data from the pad
//   vd_out/vd_oe     SRAM write data and pad driver enable
//   n_vrd/n_vwr      SRAM read / write strobes, active low
module sram_arbiter #(
   parameter int CH            = 4,
   parameter int AW            = 19,
   parameter int ACCESS_CYCLES = 2,
   parameter int RR            = 1
) (
   input  logic             clk28,
   input  logic             rst,
   input  logic [CH-1:0]    req,
   input  logic [CH-1:0]    we,
   input  logic [CH*AW-1:0] addr,
   input  logic [CH*8-1:0]  wdata,
   output logic [CH-1:0]    gnt,
   output logic [CH-1:0]    done,
   output logic [7:0]       rdata,
   output logic             busy,
   output logic [AW-1:0]    va,
   input  logic [7:0]       vd_in,
   output logic [7:0]       vd_out,
   output logic             vd_oe,
   output logic             n_vrd,
   output logic             n_vwr
);

   localparam int IW = (CH > 2) ? $clog2(CH) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [1:0]    LAST_CNT  = 2'(ACCESS_CYCLES - 1);
   localparam logic [IW-1:0] LAST_INIT = IW'(CH - 1);

   logic [1:0]    state;
   logic [1:0]    cnt;
   logic [IW-1:0] last_served;
   logic [CH-1:0] cur_oh;
   logic          cur_we;

   logic [IW-1:0] win_idx;
   logic          found;
   logic [CH-1:0] win_oh;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_wdata;
   logic          sel_we;

   // Winner selection. In round-robin mode the first pass looks only above
   // last_served; the second pass supplies the wrap-around to channel 1 upward.
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      if (req[0]) begin
         found = 1'b1;
      end else if (RR != 0) begin
         for (int i = 1; i < CH; i++) begin
            if (!found && req[i] && (IW'(i) > last_served)) begin
               win_idx = IW'(i);
               found   = 1'b1;
            end
         end
         for (int i = 1; i < CH; i++) begin
            if (!found && req[i]) begin
               win_idx = IW'(i);
               found   = 1'b1;
            end
         end
      end else begin
         for (int i = 1; i < CH; i++) begin
            if (!found && req[i]) begin
               win_idx = IW'(i);
               found   = 1'b1;
            end
         end
      end
   end

   // Request fields of the winning channel.
   always_comb begin
      win_oh    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (win_idx == IW'(i)) begin
            win_oh[i] = 1'b1;
            sel_addr  = addr[i*AW +: AW];
            sel_wdata = wdata[i*8 +: 8];
            sel_we    = we[i];
         end
      end
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_served <= LAST_INIT;
         cur_oh      <= '0;
         cur_we      <= 1'b0;
         gnt         <= '0;
         done        <= '0;
         busy        <= 1'b0;
         rdata       <= 8'hFF;
         va          <= '0;
         vd_out      <= '0;
         vd_oe       <= 1'b0;
         n_vrd       <= 1'b1;
         n_vwr       <= 1'b1;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            S_IDLE, S_DONE: begin
               if (|req) begin
                  // Strobes for the first ACCESS cycle are set here so they are
                  // registered outputs that coincide with gnt.
                  state  <= S_ACCESS;
                  cnt    <= '0;
                  cur_oh <= win_oh;
                  cur_we <= sel_we;
                  gnt    <= win_oh;
                  busy   <= 1'b1;
                  va     <= sel_addr;
                  vd_out <= sel_wdata;
                  vd_oe  <= sel_we;
                  n_vrd  <= sel_we;
                  n_vwr  <= 1'b1;
                  if (win_idx != '0) begin
                     last_served <= win_idx;
                  end
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (cnt == LAST_CNT) begin
                  // End of the last ACCESS cycle: capture read data and release
                  // the bus; vd_oe low in DONE is the turnaround cycle.
                  state <= S_DONE;
                  done  <= cur_oh;
                  if (!cur_we) begin
                     rdata <= vd_in;
                  end
                  vd_oe <= 1'b0;
                  n_vrd <= 1'b1;
                  n_vwr <= 1'b1;
               end else begin
                  // Count 0 is address/data setup; the write strobe starts at 1.
                  cnt   <= cnt + 2'd1;
                  n_vwr <= ~cur_we;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

   localparam int CH = 4;
   localparam int AW = 19;
   localparam int AC = 2;

   logic clk28 = 1'b0;
   logic rst;
   always #5 clk28 = ~clk28;

   // round-robin instance
   logic [CH-1:0]    req;
   logic [CH-1:0]    we;
   logic [CH*AW-1:0] addr;
   logic [CH*8-1:0]  wdata;
   logic [CH-1:0]    gnt, done;
   logic [7:0]       rdata, vd_in, vd_out;
   logic             busy, vd_oe, n_vrd, n_vwr;
   logic [AW-1:0]    va;
   logic [AW-1:0]    c_addr [CH];
   logic [7:0]       c_wdata [CH];

   // fixed-priority instance
   logic [CH-1:0]    req_b, we_b, gnt_b, done_b;
   logic [CH*AW-1:0] addr_b;
   logic [CH*8-1:0]  wdata_b;
   logic [7:0]       rdata_b, vd_in_b, vd_out_b;
   logic             busy_b, vd_oe_b, n_vrd_b, n_vwr_b;
   logic [AW-1:0]    va_b;

   always_comb begin
      addr  = '0;
      wdata = '0;
      for (int i = 0; i < CH; i++) begin
         addr[i*AW +: AW] = c_addr[i];
         wdata[i*8 +: 8]  = c_wdata[i];
      end
   end

   sram_arbiter #(.CH(CH), .AW(AW), .ACCESS_CYCLES(AC), .RR(1)) dut (
      .clk28(clk28), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .va(va), .vd_in(vd_in),
      .vd_out(vd_out), .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr)
   );

   sram_arbiter #(.CH(CH), .AW(AW), .ACCESS_CYCLES(AC), .RR(0)) dut_b (
      .clk28(clk28), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
      .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b), .va(va_b), .vd_in(vd_in_b),
      .vd_out(vd_out_b), .vd_oe(vd_oe_b), .n_vrd(n_vrd_b), .n_vwr(n_vwr_b)
   );

   // SRAM pad model: unwritten locations return a fixed pattern.
   bit [7:0] sram   [0:(1<<AW)-1];
   bit       sram_v [0:(1<<AW)-1];
   bit [7:0] ref_mem [0:(1<<AW)-1];
   bit       ref_v   [0:(1<<AW)-1];

   function automatic logic [7:0] dflt(logic [AW-1:0] a);
      return (a == 19'h1C000) ? 8'h5A : (a[7:0] ^ 8'h3C);
   endfunction

   function automatic logic [7:0] sram_rd(logic [AW-1:0] a);
      return sram_v[a] ? sram[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(logic [AW-1:0] a);
      return ref_v[a] ? ref_mem[a] : dflt(a);
   endfunction

   always @(posedge clk28) begin
      if (!n_vwr) begin
         sram[va]   <= vd_out;
         sram_v[va] <= 1'b1;
      end
   end

   always @(negedge clk28) begin
      vd_in <= n_vrd ? 8'h00 : sram_rd(va);
   end

   // Reference model: phase -1 idle, 0..AC-1 access cycles, AC done cycle.
   int          m_ph, m_cur, m_last;
   logic        m_we;
   logic [AW-1:0] m_addr;
   logic [7:0]  m_wdata, m_rdata;

   int errors = 0;
   int checks = 0;
   int gq[$];

   task automatic model_reset();
      m_ph    = -1;
      m_cur   = 0;
      m_last  = CH - 1;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = 8'hFF;
   endtask

   function automatic int pick(logic [CH-1:0] r);
      if (r[0]) return 0;
      for (int off = 1; off < CH; off++) begin
         int c;
         c = ((m_last - 1 + off) % (CH - 1)) + 1;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // Advance one clock and compare every output against the model.
   task automatic step();
      logic [CH-1:0] r, eg, ed;
      int gw;
      bit acc;
      r = req;
      @(posedge clk28);
      #1;
      eg = '0;
      ed = '0;
      gw = -1;
      if (m_ph == -1 || m_ph == AC) begin
         if (r != '0) begin
            gw      = pick(r);
            m_cur   = gw;
            m_we    = we[gw];
            m_addr  = c_addr[gw];
            m_wdata = c_wdata[gw];
            if (gw != 0) m_last = gw;
            m_ph    = 0;
            eg[gw]  = 1'b1;
         end else begin
            m_ph = -1;
         end
      end else if (m_ph == AC - 1) begin
         m_ph       = AC;
         ed[m_cur]  = 1'b1;
         if (m_we) begin
            ref_mem[m_addr] = m_wdata;
            ref_v[m_addr]   = 1'b1;
         end else begin
            m_rdata = ref_rd(m_addr);
         end
      end else begin
         m_ph++;
      end
      acc = (m_ph >= 0) && (m_ph < AC);

      checks++; if (gnt !== eg) begin errors++; $display("FAIL gnt t=%0t got=%b exp=%b", $time, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL done t=%0t got=%b exp=%b", $time, done, ed); end
      checks++; if (busy !== (m_ph >= 0)) begin errors++; $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, (m_ph >= 0)); end
      checks++; if (n_vrd !== !(acc && !m_we)) begin errors++; $display("FAIL n_vrd t=%0t got=%b exp=%b", $time, n_vrd, !(acc && !m_we)); end
      checks++; if (n_vwr !== !(acc && m_we && m_ph >= 1)) begin errors++; $display("FAIL n_vwr t=%0t got=%b exp=%b", $time, n_vwr, !(acc && m_we && m_ph >= 1)); end
      checks++; if (vd_oe !== (acc && m_we)) begin errors++; $display("FAIL vd_oe t=%0t got=%b exp=%b", $time, vd_oe, (acc && m_we)); end
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rdata t=%0t got=%h exp=%h", $time, rdata, m_rdata); end
      if (acc) begin
         checks++; if (va !== m_addr) begin errors++; $display("FAIL va t=%0t got=%h exp=%h", $time, va, m_addr); end
      end
      if (acc && m_we) begin
         checks++; if (vd_out !== m_wdata) begin errors++; $display("FAIL vd_out t=%0t got=%h exp=%h", $time, vd_out, m_wdata); end
      end
      for (int i = 0; i < CH; i++) if (gnt[i]) gq.push_back(i);
      if (gw >= 0) req[gw] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk28);
      @(negedge clk28);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL reset_pulses gnt=%b done=%b exp=0", gnt, done); end
      checks++; if (busy !== 1'b0 || vd_oe !== 1'b0) begin errors++; $display("FAIL reset_busy_oe busy=%b vd_oe=%b exp=0", busy, vd_oe); end
      checks++; if (n_vrd !== 1'b1 || n_vwr !== 1'b1) begin errors++; $display("FAIL reset_strobes n_vrd=%b n_vwr=%b exp=1", n_vrd, n_vwr); end
      checks++; if (va !== '0 || vd_out !== 8'h00) begin errors++; $display("FAIL reset_bus va=%h vd_out=%h exp=0", va, vd_out); end
      checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL reset_rdata got=%h exp=ff", rdata); end
      @(negedge clk28);
      rst = 1'b0;
      model_reset();
      repeat (2) step();
   endtask

   task automatic test_read();
      c_addr[1] = 19'h1C000;
      we[1]     = 1'b0;
      req[1]    = 1'b1;
      step();
      checks++; if (gnt !== 4'b0010 || n_vrd !== 1'b0) begin errors++; $display("FAIL read_c1 gnt=%b n_vrd=%b exp 0010/0", gnt, n_vrd); end
      step();
      checks++; if (n_vrd !== 1'b0) begin errors++; $display("FAIL read_c2 n_vrd=%b exp 0", n_vrd); end
      step();
      checks++; if (done !== 4'b0010 || rdata !== 8'h5A) begin errors++; $display("FAIL read_c3 done=%b rdata=%h exp 0010/5a", done, rdata); end
      step();
   endtask

   task automatic test_write();
      c_addr[2]  = 19'h00123;
      c_wdata[2] = 8'hA5;
      we[2]      = 1'b1;
      req[2]     = 1'b1;
      step();
      checks++; if (vd_oe !== 1'b1 || n_vwr !== 1'b1) begin errors++; $display("FAIL write_c1 vd_oe=%b n_vwr=%b exp 1/1", vd_oe, n_vwr); end
      step();
      checks++; if (vd_oe !== 1'b1 || n_vwr !== 1'b0) begin errors++; $display("FAIL write_c2 vd_oe=%b n_vwr=%b exp 1/0", vd_oe, n_vwr); end
      step();
      checks++; if (done !== 4'b0100 || vd_oe !== 1'b0 || rdata !== 8'h5A) begin errors++; $display("FAIL write_c3 done=%b vd_oe=%b rdata=%h exp 0100/0/5a", done, vd_oe, rdata); end
      checks++; if (sram_rd(19'h00123) !== 8'hA5) begin errors++; $display("FAIL write_mem got=%h exp=a5", sram_rd(19'h00123)); end
      we[2] = 1'b0;
      step();
   endtask

   task automatic test_rr_order();
      bit rerq;
      int exp_q[4];
      exp_q = '{0, 1, 3, 1};
      do_reset();
      gq.delete();
      rerq = 1'b0;
      for (int i = 0; i < CH; i++) begin
         we[i]     = 1'b0;
         c_addr[i] = AW'(19'h00200 + i);
      end
      req = 4'b1011;
      for (int i = 0; i < 16; i++) begin
         step();
         if (!rerq && gnt[1]) begin
            req[1] = 1'b1;
            rerq   = 1'b1;
         end
      end
      checks++; if (gq.size() != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", gq.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < gq.size()) begin
            checks++; if (gq[i] != exp_q[i]) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gq[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_fixed_prio();
      req_b = 4'b1100;
      for (int i = 0; i < 12; i++) begin
         logic [CH-1:0] eg;
         step();
         eg = (i % 3 == 0) ? 4'b0100 : 4'b0000;
         checks++; if (gnt_b !== eg) begin errors++; $display("FAIL fp_gnt i=%0d got=%b exp=%b", i, gnt_b, eg); end
         checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL fp_busy i=%0d got=%b exp=1", i, busy_b); end
      end
      req_b = 4'b1000;
      step();
      checks++; if (gnt_b !== 4'b1000) begin errors++; $display("FAIL fp_ch3 got=%b exp=1000", gnt_b); end
      req_b = 4'b0000;
      repeat (3) step();
   endtask

   task automatic test_async_reset();
      c_addr[1]  = 19'h00040;
      c_wdata[1] = 8'h77;
      we[1]      = 1'b1;
      req[1]     = 1'b1;
      step();
      step();
      #3;
      rst = 1'b1;
      #1;
      checks++; if (n_vwr !== 1'b1 || vd_oe !== 1'b0) begin errors++; $display("FAIL arst_strobes n_vwr=%b vd_oe=%b exp 1/0", n_vwr, vd_oe); end
      checks++; if (busy !== 1'b0 || done !== '0) begin errors++; $display("FAIL arst_busy busy=%b done=%b exp 0/0", busy, done); end
      @(posedge clk28);
      @(negedge clk28);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (done !== '0) begin errors++; $display("FAIL arst_nodone i=%0d got=%b exp=0", i, done); end
      end
      we[1]  = 1'b0;
      req[1] = 1'b1;
      repeat (3) step();
      checks++; if (done !== 4'b0010 || rdata !== 8'h7C) begin errors++; $display("FAIL arst_next done=%b rdata=%h exp 0010/7c", done, rdata); end
      step();
   endtask

   task automatic test_drop();
      c_addr[2] = 19'h00010;
      we[2]     = 1'b0;
      req[2]    = 1'b1;
      step();
      c_addr[1] = 19'h00011;
      we[1]     = 1'b0;
      req[1]    = 1'b1;
      step();
      req[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (gnt[1] !== 1'b0 || done[1] !== 1'b0) begin errors++; $display("FAIL drop i=%0d gnt=%b done=%b exp ch1 idle", i, gnt, done); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step();
         for (int i = 0; i < CH; i++) begin
            if (!req[i] && $urandom_range(0, (i == 0) ? 7 : 2) == 0) begin
               req[i]     = 1'b1;
               we[i]      = 1'($urandom_range(0, 1));
               c_addr[i]  = AW'($urandom_range(0, 15));
               c_wdata[i] = 8'($urandom_range(0, 255));
            end else if (req[i] && $urandom_range(0, 15) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      req = '0;
      repeat (6) step();
   endtask

   initial begin
      rst     = 1'b1;
      req     = '0;
      we      = '0;
      req_b   = '0;
      we_b    = '0;
      addr_b  = '0;
      wdata_b = '0;
      vd_in_b = 8'h00;
      for (int i = 0; i < CH; i++) begin
         c_addr[i]  = '0;
         c_wdata[i] = '0;
      end
      model_reset();
      test_reset();
      test_read();
      test_write();
      test_rr_order();
      test_fixed_prio();
      test_async_reset();
      test_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
